ravenoc_axi_initiator: RTL and testbench

// - Single-outstanding AXI4 manager. Drives one NoC AXI slave port (one router NI) from a simple command/stream I/F.
// - Issues one INCR write burst (AW->W->B) or one INCR read burst (AR->R) per command; reports completion status.
// - Used by on-chip traffic generators and test harnesses that sit on the same AXI side as the NoC.

---
 rtl/ravenoc_axi_initiator.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_ravenoc_axi_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ravenoc_axi_initiator.sv
// ravenoc_axi_initiator
//   Single-outstanding AXI4 manager driving one NoC NI slave port from a simple
//   command interface plus write/read payload streams. Each accepted command issues
//   exactly one INCR burst (AW->W->B for writes, AR->R for reads). done_o pulses
//   for one cycle at completion, and err_code_o is valid in the same cycle.
//
// Parameters
//   DATA_WIDTH  AXI data width (power of two, >= 8)
//   ADDR_WIDTH  AXI address width
//   TIMEOUT     watchdog limit in cycles spent waiting in B/R (0 disables, max 255)
//
// Ports
//   clk_axi_i, arst_axi_i              clock, synchronous active-high reset
//   cmd_*                              command request (valid/ready, dir, addr, len)
//   wr_valid_i/wr_ready_o/wr_data_i    write payload stream (pass-through to W)
//   rd_valid_o/rd_ready_i/rd_data_o/rd_last_o  read payload stream (pass-through from R)
//   done_o, err_code_o                 completion pulse and status
//                                      (0 OK, 1 SLVERR/DECERR, 2 rlast mismatch, 3 timeout)
//   m_aw*/m_w*/m_b*/m_ar*/m_r*         AXI4 manager channels
module ravenoc_axi_initiator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                      clk_axi_i,
  input  logic                      arst_axi_i,
  // Command interface
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic [7:0]                cmd_len_i,
  // Write payload stream
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [DATA_WIDTH-1:0]     wr_data_i,
  // Read payload stream
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      rd_last_o,
  // Completion
  output logic                      done_o,
  output logic [1:0]                err_code_o,
  // AW channel
  output logic                      m_awid_o,
  output logic [ADDR_WIDTH-1:0]     m_awaddr_o,
  output logic [7:0]                m_awlen_o,
  output logic [2:0]                m_awsize_o,
  output logic [1:0]                m_awburst_o,
  output logic                      m_awlock_o,
  output logic [3:0]                m_awcache_o,
  output logic [2:0]                m_awprot_o,
  output logic [3:0]                m_awqos_o,
  output logic [3:0]                m_awregion_o,
  output logic                      m_awuser_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  // W channel
  output logic [DATA_WIDTH-1:0]     m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb_o,
  output logic                      m_wlast_o,
  output logic                      m_wuser_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  // B channel
  input  logic [1:0]                m_bresp_i,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  // AR channel
  output logic                      m_arid_o,
  output logic [ADDR_WIDTH-1:0]     m_araddr_o,
  output logic [7:0]                m_arlen_o,
  output logic [2:0]                m_arsize_o,
  output logic [1:0]                m_arburst_o,
  output logic                      m_arlock_o,
  output logic [3:0]                m_arcache_o,
  output logic [2:0]                m_arprot_o,
  output logic [3:0]                m_arqos_o,
  output logic [3:0]                m_arregion_o,
  output logic                      m_aruser_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  // R channel
  input  logic [DATA_WIDTH-1:0]     m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o
);

  typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StDone} state_e;

  localparam logic [2:0] AxSize    = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [7:0] WdogLimit = 8'(TIMEOUT);
  localparam bit         WdogEn    = (TIMEOUT != 0);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [7:0]            wdog_q;
  logic                  cmd_ready_q;
  logic                  awvalid_q;
  logic                  arvalid_q;
  logic                  bready_q;
  logic                  done_q;
  logic [1:0]            err_code_q;
  logic                  err_resp_q, err_resp_d;
  logic                  err_last_q, err_last_d;

  logic       in_w, in_r;
  logic       w_hs, b_hs, r_hs;
  logic       last_beat;
  logic [7:0] cnt_inc;
  logic [7:0] wdog_inc;
  logic       wdog_expired;

  // Status priority among the sticky response errors; timeout (3) is handled at abort.
  function automatic logic [1:0] err_prio(input logic last_err, input logic resp_err);
    if (last_err) return 2'd2;
    if (resp_err) return 2'd1;
    return 2'd0;
  endfunction

  assign in_w = (state_q == StW);
  assign in_r = (state_q == StR);

  // Payload streams are combinational pass-throughs, gated by the owning state so no
  // beat can leak before the address handshake or after an abort.
  assign m_wvalid_o = in_w & wr_valid_i;
  assign m_wdata_o  = wr_data_i;
  assign m_wlast_o  = in_w & last_beat;
  assign wr_ready_o = in_w & m_wready_i;

  assign rd_valid_o = in_r & m_rvalid_i;
  assign rd_data_o  = m_rdata_i;
  assign rd_last_o  = in_r & m_rlast_i;
  assign m_rready_o = in_r & rd_ready_i;

  assign w_hs = m_wvalid_o & m_wready_i;
  assign b_hs = bready_q & m_bvalid_i;
  assign r_hs = m_rready_o & m_rvalid_i;

  assign last_beat = (cnt_q == len_q);
  // Saturate so a slave that overruns a 256-beat read cannot wrap the count.
  assign cnt_inc   = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
  // wdog_q never exceeds WdogLimit-1, so the increment cannot overflow.
  assign wdog_inc     = wdog_q + 8'd1;
  assign wdog_expired = WdogEn && (wdog_inc == WdogLimit);

  // Sticky error flags including this cycle's response, so the completion status
  // registered on the final handshake already reflects it.
  always_comb begin
    err_resp_d = err_resp_q;
    err_last_d = err_last_q;
    if (b_hs && (m_bresp_i != 2'b00)) begin
      err_resp_d = 1'b1;
    end
    if (r_hs) begin
      if (m_rresp_i != 2'b00) begin
        err_resp_d = 1'b1;
      end
      // rlast must coincide exactly with the len-th beat.
      if (m_rlast_i != last_beat) begin
        err_last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_axi_i) begin
    if (arst_axi_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wdog_q      <= '0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_code_q  <= 2'd0;
      err_resp_q  <= 1'b0;
      err_last_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_code_q <= 2'd0;
      err_resp_q <= err_resp_d;
      err_last_q <= err_last_d;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            addr_q      <= cmd_addr_i;
            len_q       <= cmd_len_i;
            cnt_q       <= '0;
            wdog_q      <= '0;
            err_resp_q  <= 1'b0;
            err_last_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            if (cmd_write_i) begin
              awvalid_q <= 1'b1;
              state_q   <= StAw;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StAr;
            end
          end
        end
        StAw: begin
          if (m_awready_i) begin
            awvalid_q <= 1'b0;
            state_q   <= StW;
          end
        end
        StW: begin
          // Stream stalls are legal here, so the watchdog does not run.
          if (w_hs) begin
            cnt_q <= cnt_inc;
            if (last_beat) begin
              bready_q <= 1'b1;
              wdog_q   <= '0;
              state_q  <= StB;
            end
          end
        end
        StB: begin
          if (b_hs) begin
            bready_q   <= 1'b0;
            done_q     <= 1'b1;
            err_code_q <= err_prio(err_last_d, err_resp_d);
            state_q    <= StDone;
          end else if (wdog_expired) begin
            bready_q   <= 1'b0;
            done_q     <= 1'b1;
            err_code_q <= 2'd3;
            state_q    <= StDone;
          end else if (WdogEn) begin
            wdog_q <= wdog_inc;
          end
        end
        StAr: begin
          if (m_arready_i) begin
            arvalid_q <= 1'b0;
            wdog_q    <= '0;
            state_q   <= StR;
          end
        end
        StR: begin
          if (r_hs) begin
            cnt_q  <= cnt_inc;
            wdog_q <= '0;
            // Only rlast terminates the burst; surplus beats are drained.
            if (m_rlast_i) begin
              done_q     <= 1'b1;
              err_code_q <= err_prio(err_last_d, err_resp_d);
              state_q    <= StDone;
            end
          end else if (wdog_expired) begin
            done_q     <= 1'b1;
            err_code_q <= 2'd3;
            state_q    <= StDone;
          end else if (WdogEn) begin
            wdog_q <= wdog_inc;
          end
        end
        StDone: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign done_o      = done_q;
  assign err_code_o  = err_code_q;

  assign m_awid_o     = 1'b0;
  assign m_awaddr_o   = addr_q;
  assign m_awlen_o    = len_q;
  assign m_awsize_o   = AxSize;
  assign m_awburst_o  = BurstIncr;
  assign m_awlock_o   = 1'b0;
  assign m_awcache_o  = 4'd0;
  assign m_awprot_o   = 3'd0;
  assign m_awqos_o    = 4'd0;
  assign m_awregion_o = 4'd0;
  assign m_awuser_o   = 1'b0;
  assign m_awvalid_o  = awvalid_q;

  assign m_wstrb_o = '1;
  assign m_wuser_o = 1'b0;

  assign m_bready_o = bready_q;

  assign m_arid_o     = 1'b0;
  assign m_araddr_o   = addr_q;
  assign m_arlen_o    = len_q;
  assign m_arsize_o   = AxSize;
  assign m_arburst_o  = BurstIncr;
  assign m_arlock_o   = 1'b0;
  assign m_arcache_o  = 4'd0;
  assign m_arprot_o   = 3'd0;
  assign m_arqos_o    = 4'd0;
  assign m_arregion_o = 4'd0;
  assign m_aruser_o   = 1'b0;
  assign m_arvalid_o  = arvalid_q;

endmodule

// File: tb/tb_ravenoc_axi_initiator.sv
module tb_ravenoc_axi_initiator;

  logic        clk = 1'b0;
  logic        arst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done;
  logic [1:0]  err_code;
  logic        awid, awlock, awuser, awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst;
  logic [3:0]  awcache, awqos, awregion;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wuser, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        arid, arlock, aruser, arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache, arqos, arregion;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ravenoc_axi_initiator #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clk_axi_i(clk), .arst_axi_i(arst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
    .done_o(done), .err_code_o(err_code),
    .m_awid_o(awid), .m_awaddr_o(awaddr), .m_awlen_o(awlen), .m_awsize_o(awsize),
    .m_awburst_o(awburst), .m_awlock_o(awlock), .m_awcache_o(awcache), .m_awprot_o(awprot),
    .m_awqos_o(awqos), .m_awregion_o(awregion), .m_awuser_o(awuser), .m_awvalid_o(awvalid),
    .m_awready_i(awready),
    .m_wdata_o(wdata), .m_wstrb_o(wstrb), .m_wlast_o(wlast), .m_wuser_o(wuser),
    .m_wvalid_o(wvalid), .m_wready_i(wready),
    .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(bready),
    .m_arid_o(arid), .m_araddr_o(araddr), .m_arlen_o(arlen), .m_arsize_o(arsize),
    .m_arburst_o(arburst), .m_arlock_o(arlock), .m_arcache_o(arcache), .m_arprot_o(arprot),
    .m_arqos_o(arqos), .m_arregion_o(arregion), .m_aruser_o(aruser), .m_arvalid_o(arvalid),
    .m_arready_i(arready),
    .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rlast_i(rlast), .m_rvalid_i(rvalid),
    .m_rready_o(rready)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] dbase;
    bit          stall;
    int          wgap;       // cycles before the write stream offers its first beat
    int          rlast_beat; // read beat on which the slave raises rlast
    int          rerr_beat;  // read beat answered with SLVERR (-1 none)
    logic [1:0]  bresp;
    bit          b_never;    // slave never answers on B
    logic [1:0]  exp_err;
    int          exp_beats;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic        rlq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic rnd(input bit en);
    if (!en) return 1'b1;
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    bit aw_seen = 0, ar_seen = 0, b_pend = 0, w_pend = 0, r_pend = 0, r_fin = 0;
    bit done_seen = 0;
    int w_idx = 0, r_beat = 0, beats = 0, t_b = 0;
    logic pv_aw = 0, pv_awr = 0, pv_w = 0, pv_wr = 0, pv_ar = 0, pv_arr = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [31:0] e;
    logic el;
    wq.delete(); rq.delete(); rlq.delete();
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      cmd_valid = (cyc == 0);
      cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
      awready = rnd(v.stall); wready = rnd(v.stall); arready = rnd(v.stall);
      rd_ready = rnd(v.stall);
      // Write source holds each beat until it is taken.
      if (!w_pend) begin
        if (v.wr && cyc >= v.wgap && w_idx <= int'(v.len) && rnd(v.stall)) begin
          wr_valid = 1'b1;
          wr_data  = v.dbase + 32'(w_idx);
          wq.push_back(wr_data);
          w_pend = 1;
        end else begin
          wr_valid = 1'b0;
        end
      end
      bvalid = b_pend && !v.b_never;
      bresp  = v.bresp;
      if (!r_pend) begin
        if (ar_seen && !r_fin && rnd(v.stall)) begin
          rvalid = 1'b1;
          rdata  = v.dbase + 32'(r_beat);
          rlast  = (r_beat == v.rlast_beat);
          rresp  = (r_beat == v.rerr_beat) ? 2'b10 : 2'b00;
          rq.push_back(rdata);
          rlq.push_back(rlast);
          r_pend = 1;
        end else begin
          rvalid = 1'b0;
        end
      end
      #1;
      if (cyc == 0) chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      if (cyc == 1) chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (pv_aw && !pv_awr) begin
        chk("aw_valid_hold", 32'(awvalid), 32'd1);
        chk("aw_addr_hold", awaddr, p_awaddr);
      end
      if (pv_ar && !pv_arr) begin
        chk("ar_valid_hold", 32'(arvalid), 32'd1);
        chk("ar_addr_hold", araddr, p_araddr);
      end
      if (pv_w && !pv_wr) begin
        chk("w_valid_hold", 32'(wvalid), 32'd1);
        chk("w_data_hold", wdata, p_wdata);
      end
      if (wvalid && !aw_seen) chk("w_before_aw", 32'(wvalid), 32'd0);
      if (awvalid && awready) begin
        chk("aw_addr", awaddr, v.addr);
        chk("aw_len", 32'(awlen), 32'(v.len));
        chk("aw_size_burst", {27'd0, awsize, awburst}, {27'd0, 3'd2, 2'b01});
        aw_seen = 1;
      end
      if (wvalid && wready) begin
        e = (wq.size() > 0) ? wq.pop_front() : 32'hxxxxxxxx;
        chk("w_data", wdata, e);
        chk("w_last", 32'(wlast), 32'(w_idx == int'(v.len)));
        chk("w_strb", 32'(wstrb), 32'hf);
        chk("wr_ready", 32'(wr_ready), 32'd1);
        if (w_idx == int'(v.len)) begin
          b_pend = 1;
          t_b = cyc;
        end
        w_pend = 0;
        w_idx++;
        beats++;
      end
      if (b_pend && cyc > t_b && !done) chk("b_ready", 32'(bready), 32'd1);
      if (bvalid && bready) b_pend = 0;
      if (arvalid && arready) begin
        chk("ar_addr", araddr, v.addr);
        chk("ar_len", 32'(arlen), 32'(v.len));
        ar_seen = 1;
      end
      if (rvalid && rready) begin
        e  = (rq.size() > 0) ? rq.pop_front() : 32'hxxxxxxxx;
        el = (rlq.size() > 0) ? rlq.pop_front() : 1'bx;
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, e);
        chk("rd_last", 32'(rd_last), 32'(el));
        if (rlast) r_fin = 1;
        r_pend = 0;
        r_beat++;
        beats++;
      end
      if (done) begin
        chk($sformatf("v%0d_err", id), 32'(err_code), 32'(v.exp_err));
        chk($sformatf("v%0d_beats", id), 32'(beats), 32'(v.exp_beats));
        if (v.b_never) chk("timeout_latency", 32'(cyc - t_b), 32'd17);
        done_seen = 1;
      end
      pv_aw = awvalid; pv_awr = awready; p_awaddr = awaddr;
      pv_ar = arvalid; pv_arr = arready; p_araddr = araddr;
      pv_w = wvalid; pv_wr = wready; p_wdata = wdata;
    end
    if (!done_seen) chk($sformatf("v%0d_done_seen", id), 32'd0, 32'd1);
    // Back in IDLE; a late B after a timeout must be ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_inputs();
      bvalid = v.b_never;
      #1;
      chk("post_done", 32'(done), 32'd0);
      chk("post_bready", 32'(bready), 32'd0);
      chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    int hs;
    //         wr    addr        len  dbase        stl gap rl  re  bresp nb  err  beats
    vecs[0] = '{1'b1, 32'h1000, 8'd3, 32'h000000A0, 0, 0, -1, -1, 2'b00, 0, 2'd0, 4};
    vecs[1] = '{1'b0, 32'h2000, 8'd0, 32'hDEADBEEF, 0, 0,  0, -1, 2'b00, 0, 2'd0, 1};
    vecs[2] = '{1'b1, 32'h3000, 8'd7, 32'h00000100, 1, 0, -1, -1, 2'b00, 0, 2'd0, 8};
    vecs[3] = '{1'b0, 32'h4000, 8'd3, 32'h00000200, 0, 0,  1, -1, 2'b00, 0, 2'd2, 2};
    vecs[4] = '{1'b0, 32'h4100, 8'd3, 32'h00000300, 0, 0,  3,  2, 2'b00, 0, 2'd1, 4};
    vecs[5] = '{1'b1, 32'h5000, 8'd0, 32'h00000400, 0, 0, -1, -1, 2'b11, 0, 2'd1, 1};
    vecs[6] = '{1'b0, 32'h6000, 8'd2, 32'h00000500, 1, 0,  2, -1, 2'b00, 0, 2'd0, 3};
    vecs[7] = '{1'b0, 32'h7000, 8'd1, 32'h00000600, 0, 0,  3, -1, 2'b00, 0, 2'd2, 4};
    vecs[8] = '{1'b1, 32'h8000, 8'd0, 32'h00000700, 0, 0, -1, -1, 2'b00, 1, 2'd3, 1};
    vecs[9] = '{1'b1, 32'h9000, 8'd1, 32'h00000800, 0, 30, -1, -1, 2'b00, 0, 2'd0, 2};

    idle_inputs();
    arst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, rd_valid, done},  32'd0);
    chk("rst_readies", {30'd0, bready, rready}, 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    @(negedge clk);
    arst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset while beat 2 of an 8-beat write is on the bus.
    hs = 0;
    for (int cyc = 0; cyc < 20 && hs < 2; cyc++) begin
      @(negedge clk);
      cmd_valid = (cyc == 0); cmd_write = 1'b1; cmd_addr = 32'hA000; cmd_len = 8'd7;
      awready = 1'b1; wready = 1'b1; wr_valid = 1'b1; wr_data = 32'h500 + 32'(hs);
      #1;
      if (wvalid && wready) hs++;
    end
    chk("rst_mid_beats", 32'(hs), 32'd2);
    @(negedge clk);
    cmd_valid = 1'b0; wr_data = 32'h502;
    arst = 1'b1;
    #1;
    chk("rst_mid_wvalid_pre", 32'(wvalid), 32'd1);
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("rst_mid_valids", {28'd0, awvalid, wvalid, arvalid, rd_valid}, 32'd0);
    chk("rst_mid_readies", {29'd0, bready, rready, wr_ready}, 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      chk("rst_mid_no_done", 32'(done), 32'd0);
    end

    run_vec(vecs[0], 10);
    run_vec(vecs[1], 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
